// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the two-source FIFO arbiter/scheduler.
// Optional grant statistics are enabled by FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  localparam int FIFO_DEPTH = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } rd_st_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer always moves to the
// source that was not just granted.
module rr_arb2
  import fifo_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en) begin
      if (req == 2'b11) gnt[ptr_q] = 1'b1;
      else              gnt        = req;
    end
    if (gnt[SRC_A]) ptr_d = SRC_B;
    if (gnt[SRC_B]) ptr_d = SRC_A;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= SRC_A;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_arb_sched.sv
// Shared SRL16 FIFO controller: arbitrated write stage, burst reader.
// Define FIFO_ARB_STATS_EN to add per-source grant counters.
module fifo_arb_sched
  import fifo_arb_pkg::*;
#(
  parameter int unsigned BURST = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_d,
  input  logic        a_v,
  output logic        a_rdy,
  input  logic [15:0] b_d,
  input  logic        b_v,
  output logic        b_rdy,
  output logic [15:0] fifo_pdi,
  output logic        fifo_iv,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        fifo_oe,
  input  logic        fifo_ov,
  input  logic        rd_req,
  output logic        burst_act,
  output logic [3:0]  level,
  output logic        ovf
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0] cnt_a,
  output logic [15:0] cnt_b
`endif
);

  logic [1:0]  gnt;
  logic        space;
  logic        iv_q;
  logic [15:0] pdi_q;
  logic [3:0]  level_q, level_d;
  logic        ovf_q;
  logic        wr_hit, rd_hit;
  rd_st_e      st_q;
  logic [3:0]  cnt_q, gcnt_q;
  logic        oe_q, act_q;

  // The write sitting in the pipeline register already owns a slot.
  assign space = ({1'b0, level_q} + {4'b0, iv_q})
               < 5'(FIFO_DEPTH);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_v, a_v}),
    .en  (space),
    .gnt (gnt)
  );

  assign a_rdy = gnt[SRC_A];
  assign b_rdy = gnt[SRC_B];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iv_q  <= 1'b0;
      pdi_q <= '0;
    end else begin
      iv_q <= |gnt;
      if (gnt[SRC_B])      pdi_q <= b_d;
      else if (gnt[SRC_A]) pdi_q <= a_d;
    end
  end

  assign wr_hit = iv_q & ~fifo_full;
  assign rd_hit = fifo_ov & ~fifo_empty;

  always_comb begin
    level_d = level_q;
    unique case ({wr_hit, fifo_ov})
      2'b10: if (level_q != 4'd15) level_d = level_q + 4'd1;
      2'b01: if (level_q != 4'd0)  level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      if (iv_q && fifo_full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      gcnt_q <= '0;
      oe_q   <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (rd_req && level_q >= 4'(BURST)) begin
            st_q  <= ST_RUN;
            cnt_q <= 4'(BURST);
            oe_q  <= 1'b1;
            act_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rd_hit) begin
            if (cnt_q == 4'd1) begin
              oe_q  <= 1'b0;
              act_q <= 1'b0;
              if (GAP == 0) begin
                st_q <= ST_IDLE;
              end else begin
                st_q   <= ST_GAP;
                gcnt_q <= 4'(GAP);
              end
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (gcnt_q == 4'd1) st_q <= ST_IDLE;
          else                gcnt_q <= gcnt_q - 4'd1;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_iv   = iv_q;
  assign fifo_pdi  = pdi_q;
  assign fifo_oe   = oe_q;
  assign burst_act = act_q;
  assign level     = level_q;
  assign ovf       = ovf_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (gnt[SRC_A]) cnt_a_q <= sat_inc16(cnt_a_q);
      if (gnt[SRC_B]) cnt_b_q <= sat_inc16(cnt_b_q);
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_fifo_arb_sched.sv
// Directed + random bench for fifo_arb_sched with a queue-based FIFO
// and an occupancy/burst reference model.
module tb_fifo_arb_sched;

  localparam int BURST = 4;
  localparam int GAP   = 1;

  logic        clk;
  logic        rst;
  logic [15:0] a_d, b_d;
  logic        a_v, b_v;
  logic        a_rdy, b_rdy;
  logic [15:0] fifo_pdi;
  logic        fifo_iv;
  logic        fifo_full, fifo_empty;
  logic        fifo_oe, fifo_ov;
  logic        rd_req;
  logic        burst_act;
  logic [3:0]  level;
  logic        ovf;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  fifo_arb_sched #(.BURST(BURST), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_d        (a_d),
    .a_v        (a_v),
    .a_rdy      (a_rdy),
    .b_d        (b_d),
    .b_v        (b_v),
    .b_rdy      (b_rdy),
    .fifo_pdi   (fifo_pdi),
    .fifo_iv    (fifo_iv),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_oe    (fifo_oe),
    .fifo_ov    (fifo_ov),
    .rd_req     (rd_req),
    .burst_act  (burst_act),
    .level      (level),
    .ovf        (ovf)
`ifdef FIFO_ARB_STATS_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_ov = fifo_oe & ~fifo_empty;

  int n_chk;
  int n_fail;

  // FIFO environment
  logic [15:0] fq[$];
  bit          force_full;

  // Reference model
  int          m_lvl;
  bit          m_iv;
  logic [15:0] m_pdi;
  bit          m_ovf;
  bit          m_ptr;
  int          m_mode;
  int          m_rem;
  int          m_grem;
  int          m_cnta, m_cntb;
  int          m_gcount;
  int          d_gcount;
  int          n_ov;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic upd_flags();
    fifo_empty = (fq.size() == 0);
    fifo_full  = (fq.size() >= 15) || force_full;
  endtask

  task automatic mreset();
    m_lvl = 0; m_iv = 0; m_pdi = '0; m_ovf = 0; m_ptr = 0;
    m_mode = 0; m_rem = 0; m_grem = 0;
    m_cnta = 0; m_cntb = 0;
    fq.delete();
    force_full = 0;
    upd_flags();
  endtask

  task automatic cyc();
    bit          space, ga, gb, ov, full_s, rq_s, inc;
    bit          env_wr, env_ov;
    logic [15:0] env_pdi, ad_s, bd_s;
    int          lvl_old;
    #1;
    space = (m_lvl + int'(m_iv)) < 15;
    ga = a_v && space && (!b_v || m_ptr == 0);
    gb = b_v && space && (!a_v || m_ptr == 1);
    chk("a_rdy", 32'(a_rdy), 32'(ga));
    chk("b_rdy", 32'(b_rdy), 32'(gb));
    ov      = (m_mode == 1) && !fifo_empty;
    full_s  = fifo_full;
    rq_s    = rd_req;
    ad_s    = a_d;
    bd_s    = b_d;
    env_wr  = fifo_iv && !fifo_full;
    env_ov  = fifo_ov;
    env_pdi = fifo_pdi;
    if (ga || gb) m_gcount++;
    if (a_rdy || b_rdy) d_gcount++;
    if (fifo_ov) n_ov++;
    @(posedge clk);
    #1;
    if (env_wr) fq.push_back(env_pdi);
    if (env_ov && fq.size() > 0) void'(fq.pop_front());
    lvl_old = m_lvl;
    inc = m_iv && !full_s;
    if (inc && !ov) m_lvl = (m_lvl < 15) ? m_lvl + 1 : 15;
    else if (ov && !inc) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
    if (m_iv && full_s) m_ovf = 1;
    case (m_mode)
      0: if (rq_s && lvl_old >= BURST) begin
        m_mode = 1; m_rem = BURST;
      end
      1: if (ov) begin
        if (m_rem == 1) begin
          if (GAP > 0) begin m_mode = 2; m_grem = GAP; end
          else m_mode = 0;
        end else m_rem--;
      end
      default: if (m_grem == 1) m_mode = 0; else m_grem--;
    endcase
    m_iv = ga || gb;
    if (gb) m_pdi = bd_s;
    else if (ga) m_pdi = ad_s;
    if (ga) begin m_ptr = 1; if (m_cnta < 65535) m_cnta++; end
    if (gb) begin m_ptr = 0; if (m_cntb < 65535) m_cntb++; end
    upd_flags();
    chk("fifo_iv", 32'(fifo_iv), 32'(m_iv));
    chk("fifo_pdi", 32'(fifo_pdi), 32'(m_pdi));
    chk("level", 32'(level), m_lvl);
    chk("level_vs_fifo", 32'(level), fq.size());
    chk("fifo_oe", 32'(fifo_oe), 32'(m_mode == 1));
    chk("burst_act", 32'(burst_act), 32'(m_mode == 1));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef FIFO_ARB_STATS_EN
    chk("cnt_a", 32'(cnt_a), m_cnta);
    chk("cnt_b", 32'(cnt_b), m_cntb);
`endif
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max);
    int k = 0;
    while (m_mode != 0 && k < max) begin
      cyc();
      k++;
    end
    chk("idle_bound", 32'(burst_act), 32'(0));
  endtask

  int base_g;

  initial begin
    n_chk = 0; n_fail = 0;
    m_gcount = 0; d_gcount = 0; n_ov = 0;
    rst = 1'b0;
    a_v = 0; b_v = 0; a_d = '0; b_d = '0; rd_req = 0;
    mreset();
    #3;
    chk("rst_iv", 32'(fifo_iv), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_oe", 32'(fifo_oe), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Contended fill from empty
    a_v = 1; b_v = 1;
    d_gcount = 0;
    for (int i = 0; i < 20; i++) begin
      a_d = 16'($urandom); b_d = 16'($urandom);
      cyc();
    end
    chk("fill_grants", d_gcount, 32'(15));
    chk("fill_level", 32'(level), 32'(15));
    chk("fill_ovf", 32'(ovf), 32'(0));

    // Drain in bursts down to 3
    a_v = 0; b_v = 0; rd_req = 1;
    repeat (30) cyc();
    chk("hold_lvl3", 32'(level), 32'(3));
    chk("hold_idle", 32'(burst_act), 32'(0));

    // One more word unlocks exactly one burst
    n_ov = 0;
    a_v = 1; a_d = 16'h1234;
    cyc();
    a_v = 0;
    repeat (14) cyc();
    chk("burst_ov4", n_ov, 32'(4));
    chk("burst_lvl0", 32'(level), 32'(0));
    rd_req = 0;

    // Single source: grants every cycle, pointer ends on B
    a_v = 1; a_d = 16'h1234;
    repeat (5) cyc();
    b_v = 1; b_d = 16'hBEEF;
    #1;
    chk("ptr_b_wins", 32'(b_rdy), 32'(1));
    chk("ptr_a_loses", 32'(a_rdy), 32'(0));
    cyc();
    a_v = 0; b_v = 0;
    repeat (2) cyc();
    chk("lvl6", 32'(level), 32'(6));

    // Writes overlapping a burst
    base_g = m_gcount;
    rd_req = 1; a_v = 1;
    a_d = 16'($urandom);
    cyc();
    rd_req = 0;
    for (int i = 0; i < 5; i++) begin
      a_d = 16'($urandom);
      cyc();
    end
    a_v = 0;
    run_until_idle(20);
    repeat (2) cyc();
    chk("overlap_lvl", 32'(level), 6 + (m_gcount - base_g) - BURST);

    // Asynchronous reset in the middle of a burst
    rd_req = 1;
    repeat (2) cyc();
    chk("pre_rst_run", 32'(burst_act), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_iv", 32'(fifo_iv), 32'(0));
    chk("arst_pdi", 32'(fifo_pdi), 32'(0));
    chk("arst_oe", 32'(fifo_oe), 32'(0));
    chk("arst_act", 32'(burst_act), 32'(0));
    chk("arst_level", 32'(level), 32'(0));
    chk("arst_ovf", 32'(ovf), 32'(0));
    rd_req = 0;
    mreset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      a_v = 1'($urandom_range(0, 1));
      b_v = 1'($urandom_range(0, 1));
      a_d = 16'($urandom);
      b_d = 16'($urandom);
      rd_req = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Overflow flag is sticky until reset
    a_v = 0; b_v = 0; rd_req = 1;
    repeat (40) cyc();
    rd_req = 0;
    run_until_idle(20);
    a_v = 1; a_d = 16'h5A5A;
    cyc();
    a_v = 0;
    force_full = 1;
    upd_flags();
    cyc();
    force_full = 0;
    upd_flags();
    repeat (3) cyc();
    chk("ovf_sticky", 32'(ovf), 32'(1));
    rst = 1'b0;
    #1;
    chk("ovf_cleared", 32'(ovf), 32'(0));
    mreset();
    @(negedge clk);
    rst = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_arb_sched.md
Name: fifo_arb_sched

Overview:
Controller that shares one 15-entry SRL16 sample FIFO (16-bit, fifo16x16s-style flags) between two sample sources and schedules burst reads out of it.
- Write side: round-robin arbiter with a registered write stage.
- Read side: burst sequencer that drains exactly BURST words per downstream request, then enforces an idle gap.
- Sits between the two decimator outputs and the shared FIFO feeding the DSP/host interface.

Parameters:
BURST, 4, words read per burst; legal range 1..15
GAP, 1, idle cycles after each burst before the next can start; legal range 0..15

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
a_d  in  16  source A sample
a_v  in  1  source A valid
a_rdy  out  1  source A sample accepted this cycle
b_d  in  16  source B sample
b_v  in  1  source B valid
b_rdy  out  1  source B sample accepted this cycle
fifo_pdi  out  16  FIFO write data (registered)
fifo_iv  out  1  FIFO write strobe (registered)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_oe  out  1  FIFO read enable
fifo_ov  in  1  FIFO output valid (oe & ~empty)
rd_req  in  1  downstream burst request, level-sensitive
burst_act  out  1  high while burst words are being read
level  out  4  mirrored FIFO occupancy, 0..15
ovf  out  1  sticky error: fifo_iv while fifo_full

Behaviour:
- Reset (rst=0, asynchronous): fifo_iv=0, fifo_pdi=0, fifo_oe=0, burst_act=0, level=0, ovf=0, priority pointer=A, state=IDLE.
- Capacity: space = (level + fifo_iv) < 15. Accounting counts the write already in the pipeline register.
- Grant (combinational):
  - Only A valid: a_rdy = a_v & space.
  - Only B valid: b_rdy = b_v & space.
  - Both valid: the source named by the pointer wins; the other's rdy=0.
  - Pointer flips to the other source after every grant. A single-source grant also flips it.
- Write stage: on a grant, next cycle fifo_iv=1 and fifo_pdi = the granted data. Latency is 1 clk from rdy to fifo_iv. Without a grant, fifo_iv=0 and fifo_pdi holds its value.
- level update:
  - +1 on fifo_iv & ~fifo_full.
  - -1 on fifo_ov.
  - Both in the same cycle: unchanged.
  - Never wraps; saturates at 0 and 15 defensively.
- ovf: set on fifo_iv & fifo_full; cleared only by reset.
- Read state machine:
  - IDLE: fifo_oe=0. If rd_req & level >= BURST, go to RUN with cnt=BURST.
  - RUN: fifo_oe=1, burst_act=1. cnt decrements on each fifo_ov. When cnt=1 and fifo_ov: go to GAP with gcnt=GAP, or to IDLE if GAP=0. fifo_empty mid-burst stalls the count; no timeout.
  - GAP: fifo_oe=0. gcnt decrements each cycle; at 1, go to IDLE.
- Reads and writes in the same cycle are legal. Entry into RUN uses the level registered before that cycle's write.
- Dropping rd_req during RUN does not abort the burst.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds outputs cnt_a[15:0] and cnt_b[15:0], counting grants per source. Both reset to 0 and saturate at 16'hFFFF.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - FIFO_DEPTH=15.
  - Read-state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_GAP=2'd2.
  - Source IDs SRC_A=1'b0, SRC_B=1'b1.
- Sub-module rr_arb2: inputs req[1:0], en (=space); outputs gnt[1:0]; holds the pointer register. Also reset by rst.

Test Plan:
- Reset mid-burst (level=8, RUN): assert rst=0 -> all outputs 0, state IDLE immediately, without waiting for clk.
- a_v=b_v=1 continuously, FIFO empty -> grants alternate A,B,A,B…; fifo_iv follows 1 clk later; exactly 15 grants, then a_rdy=b_rdy=0; level=15; ovf=0.
- Only a_v=1 with a_d=16'h1234 -> a_rdy every cycle while space; pointer flips each grant, so the next contended cycle grants B.
- level=3, BURST=4, rd_req=1 -> stays IDLE. One more write -> RUN. Exactly 4 fifo_ov pulses, then GAP for 1 cycle, then IDLE; level=0.
- Concurrent write and read in RUN (level=6) -> level unchanged on overlapping cycles; final level = 6 + writes - 4.
- Force fifo_full=1 while fifo_iv=1 -> ovf=1 and stays 1 until reset.
